ov7670_stream_gen: RTL and testbench

Synthesisable OV7670 sensor emulator: drives the camera-side bus (vsync, href, byte-wide RGB565 data) with VGA-compatible framing and selectable test patterns. It is the transmitter counterpart of the capture path. It replaces the physical sensor in simulation and on-board bring-up, so the decimating capture, frame buffer and display chain can be checked against known pixel content.

---
 rtl/ov7670_pkg.sv | 40 ++++
 rtl/ov7670_pattern_gen.sv | 79 +++++++
 rtl/ov7670_stream_gen.sv | 172 +++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 sensor emulator.
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_COUNT = 2'd3;

  // RGB565 bar colours, left to right
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Test-pattern pixel for the next output position; combinational apart from the bar
// and pixel counters, whose look-ahead values feed both their registers and the pixel.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_line_start,
  input  logic        i_pix_adv,
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  logic [1:0]  i_pat,
  input  logic [15:0] i_solid,
  output logic [15:0] o_pix
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [2:0]     r_bar_idx;
  logic [2:0]     w_bar_idx_nxt;
  logic [BPW-1:0] r_bar_pos;
  logic [BPW-1:0] w_bar_pos_nxt;
  logic [15:0]    r_pix_cnt;
  logic [15:0]    w_pix_cnt_nxt;
  logic [4:0]     w_sum;

  always_comb begin
    w_bar_idx_nxt = r_bar_idx;
    w_bar_pos_nxt = r_bar_pos;
    if (i_line_start) begin
      w_bar_idx_nxt = 3'd0;
      w_bar_pos_nxt = '0;
    end else if (i_pix_adv) begin
      if (r_bar_pos == BPW'(BAR_W - 1)) begin
        w_bar_idx_nxt = r_bar_idx + 3'd1;
        w_bar_pos_nxt = '0;
      end else begin
        w_bar_pos_nxt = r_bar_pos + BPW'(1);
      end
    end
  end

  always_comb begin
    w_pix_cnt_nxt = r_pix_cnt;
    if (i_clr)
      w_pix_cnt_nxt = 16'd0;
    else if (i_pix_adv)
      w_pix_cnt_nxt = r_pix_cnt + 16'd1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_bar_idx <= 3'd0;
      r_bar_pos <= '0;
      r_pix_cnt <= 16'd0;
    end else begin
      r_bar_idx <= w_bar_idx_nxt;
      r_bar_pos <= w_bar_pos_nxt;
      r_pix_cnt <= w_pix_cnt_nxt;
    end
  end

  // Only the low five bits of the full-width x+y sum reach the blue field.
  assign w_sum = i_x[4:0] + i_y[4:0];

  always_comb begin
    case (i_pat)
      PAT_SOLID: o_pix = i_solid;
      PAT_BARS:  o_pix = bar_colour(w_bar_idx_nxt);
      PAT_RAMP:  o_pix = {i_x[7:3], i_y[7:2], w_sum};
      default:   o_pix = w_pix_cnt_nxt;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera-bus emulator (vsync/href/RGB565 bytes); all outputs registered, no backpressure.
// Define OV7670_GEN_CHECKSUM_EN to build the per-frame pixel checksum on frame_sum.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int   H_ACTIVE      = 640,
  parameter int   V_ACTIVE      = 480,
  parameter int   H_BLANK       = 288,
  parameter int   VSYNC_LINES   = 3,
  parameter int   V_BACK        = 17,
  parameter int   V_FRONT       = 10,
  parameter logic HI_BYTE_FIRST = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  localparam int LINE_CYCLES = 2 * H_ACTIVE + H_BLANK;
  localparam int HW          = $clog2(LINE_CYCLES);
  localparam int VW          = 10;
  localparam logic [HW:0] HREF_END = (HW + 1)'(2 * H_ACTIVE);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hc;
  logic [HW-1:0] w_hc_nxt;
  logic [VW-1:0] r_vc;
  logic [VW-1:0] w_vc_nxt;
  logic [VW-1:0] w_nlines;
  logic [1:0]    r_pat;
  logic [15:0]   r_solid;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_d;
  logic          r_frame_done;

  logic          w_line_end;
  logic          w_frame_start;
  logic          w_href_nxt;
  logic          w_last_nxt;
  logic          w_pix_adv;
  logic          w_hi_sel;
  logic [7:0]    w_byte;
  logic [15:0]   w_pix;

  always_comb begin
    case (r_state)
      VSYNC:   w_nlines = VW'(VSYNC_LINES);
      VBACK:   w_nlines = VW'(V_BACK);
      ACTIVE:  w_nlines = VW'(V_ACTIVE);
      VFRONT:  w_nlines = VW'(V_FRONT);
      default: w_nlines = VW'(1);
    endcase
  end

  assign w_line_end = (r_hc == HW'(LINE_CYCLES - 1));

  // Look-ahead position: outputs are registered from it so they line up with the state.
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = '0;
    w_vc_nxt    = r_vc;
    if (r_state == IDLE) begin
      w_vc_nxt = '0;
      if (enable)
        w_state_nxt = VSYNC;
    end else if (!w_line_end) begin
      w_hc_nxt = r_hc + HW'(1);
    end else if (r_vc != w_nlines - VW'(1)) begin
      w_vc_nxt = r_vc + VW'(1);
    end else begin
      w_vc_nxt = '0;
      case (r_state)
        VSYNC:   w_state_nxt = VBACK;
        VBACK:   w_state_nxt = ACTIVE;
        ACTIVE:  w_state_nxt = VFRONT;
        VFRONT:  w_state_nxt = enable ? VSYNC : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_frame_start = (w_state_nxt == VSYNC) && (r_state != VSYNC);
  assign w_href_nxt    = (w_state_nxt == ACTIVE) && ({1'b0, w_hc_nxt} < HREF_END);
  assign w_last_nxt    = (w_state_nxt == VFRONT) && (w_vc_nxt == VW'(V_FRONT - 1)) &&
                         (w_hc_nxt == HW'(LINE_CYCLES - 1));
  assign w_pix_adv     = r_href & r_hc[0];
  assign w_hi_sel      = (w_hc_nxt[0] == ~HI_BYTE_FIRST);
  assign w_byte        = w_hi_sel ? w_pix[15:8] : w_pix[7:0];

  ov7670_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .pclk         (pclk),
    .rst          (rst),
    .i_clr        (w_frame_start),
    .i_line_start (w_hc_nxt == '0),
    .i_pix_adv    (w_pix_adv),
    .i_x          (8'(w_hc_nxt >> 1)),
    .i_y          (w_vc_nxt[7:0]),
    .i_pat        (r_pat),
    .i_solid      (r_solid),
    .o_pix        (w_pix)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hc         <= '0;
      r_vc         <= '0;
      r_pat        <= PAT_SOLID;
      r_solid      <= 16'd0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_d          <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_vc    <= w_vc_nxt;
      if (w_frame_start) begin
        r_pat   <= pattern_sel;
        r_solid <= solid_rgb;
      end
      r_vsync      <= (w_state_nxt == VSYNC);
      r_href       <= w_href_nxt;
      r_d          <= w_href_nxt ? w_byte : 8'd0;
      r_frame_done <= w_last_nxt;
    end
  end

  assign vsync      = r_vsync;
  assign href       = r_href;
  assign d          = r_d;
  assign frame_done = r_frame_done;

`ifdef OV7670_GEN_CHECKSUM_EN
  logic [15:0] r_pix;
  logic [15:0] r_acc;
  logic [15:0] r_frame_sum;

  // r_pix is the pixel currently on the bus; it is summed once, on its second byte.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_pix       <= 16'd0;
      r_acc       <= 16'd0;
      r_frame_sum <= 16'd0;
    end else begin
      r_pix <= w_pix;
      if (w_frame_start)
        r_acc <= 16'd0;
      else if (w_pix_adv)
        r_acc <= r_acc + r_pix;
      if (w_last_nxt)
        r_frame_sum <= r_acc;
    end
  end

  assign frame_sum = r_frame_sum;
`else
  assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench: small framing, both byte orders, all patterns, enable drop and async reset.
`timescale 1ns/1ps
module tb_ov7670_stream_gen;

  localparam int LC    = 20;
  localparam int FRAME = 140;
  localparam int NFR   = 7;
  localparam int NVEC  = 21;
`ifdef OV7670_GEN_CHECKSUM_EN
  localparam logic [15:0] SUM_COUNT = 16'd496;
  localparam logic [15:0] SUM_GREEN = 16'hFC00;
`else
  localparam logic [15:0] SUM_COUNT = 16'd0;
  localparam logic [15:0] SUM_GREEN = 16'd0;
`endif

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'hF81F;
  logic        vsync, href, frame_done;
  logic [7:0]  d;
  logic [15:0] frame_sum;
  logic        vsync_b, href_b, frame_done_b;
  logic [7:0]  d_b;
  logic [15:0] frame_sum_b;

  int tests = 0;
  int failed = 0;

  typedef struct {
    int          frame;
    int          y;
    int          x;
    logic [15:0] exp_pix;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [1:0]  cfg_pat [NFR];
  logic [15:0] cfg_solid [NFR];
  logic [15:0] cap_a [NFR][4][8];
  logic [15:0] cap_b [NFR][4][8];
  logic [15:0] fsum_cap [NFR];
  logic [7:0]  first_a [NFR];
  logic [7:0]  first_b [NFR];

  always #5 pclk = ~pclk;

  ov7670_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .HI_BYTE_FIRST(1'b1)
  ) dut_a (
    .pclk(pclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vsync(vsync), .href(href), .d(d), .frame_done(frame_done), .frame_sum(frame_sum)
  );

  ov7670_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .HI_BYTE_FIRST(1'b0)
  ) dut_b (
    .pclk(pclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vsync(vsync_b), .href(href_b), .d(d_b), .frame_done(frame_done_b), .frame_sum(frame_sum_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Captures one frame starting at the vsync rise and checks framing cycle by cycle.
  task automatic run_frame(input int k, input int exp_wait, input logic drop_en);
    int waited;
    int bad;
    logic [7:0] da [FRAME];
    logic [7:0] db [FRAME];
    waited = 0;
    bad = 0;
    while (vsync !== 1'b1 && waited < 400) begin
      @(negedge pclk);
      waited++;
    end
    if (vsync !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL vsync_timeout_f%0d: no vsync within %0d cycles", k, waited);
      return;
    end
    check($sformatf("vsync_start_f%0d", k), waited, exp_wait);
    for (int t = 0; t < FRAME; t++) begin
      int   ln;
      int   h;
      logic ev, eh, ef;
      ln = t / LC;
      h  = t % LC;
      ev = (t < LC);
      eh = (ln >= 2) && (ln < 6) && (h < 16);
      ef = (t == FRAME - 1);
      if (vsync !== ev || vsync_b !== ev) bad++;
      if (href !== eh || href_b !== eh) bad++;
      if (frame_done !== ef || frame_done_b !== ef) bad++;
      if (!eh && (d !== 8'd0 || d_b !== 8'd0)) bad++;
      if (href === 1'b1 && vsync === 1'b1) bad++;
      da[t] = d;
      db[t] = d_b;
      if (ef) fsum_cap[k] = frame_sum;
      if (t == 69) begin
        if (k + 1 < NFR) begin
          pattern_sel = cfg_pat[k + 1];
          solid_rgb   = cfg_solid[k + 1];
        end
        if (drop_en) enable = 1'b0;
      end
      if (t < FRAME - 1) @(negedge pclk);
    end
    check($sformatf("framing_f%0d", k), bad, 0);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        int b;
        b = (y + 2) * LC + 2 * x;
        cap_a[k][y][x] = {da[b], da[b + 1]};
        cap_b[k][y][x] = {db[b + 1], db[b]};
      end
    end
    first_a[k] = da[2 * LC];
    first_b[k] = db[2 * LC];
  endtask

  initial begin
    int busy;
    int hits;
    cfg_pat[0] = 2'd0; cfg_solid[0] = 16'hF81F;
    cfg_pat[1] = 2'd1; cfg_solid[1] = 16'h1234;
    cfg_pat[2] = 2'd2; cfg_solid[2] = 16'hABCD;
    cfg_pat[3] = 2'd3; cfg_solid[3] = 16'h5555;
    cfg_pat[4] = 2'd3; cfg_solid[4] = 16'hAAAA;
    cfg_pat[5] = 2'd1; cfg_solid[5] = 16'h0F0F;
    cfg_pat[6] = 2'd0; cfg_solid[6] = 16'h07E0;

    vecs[0]  = '{0, 0, 0, 16'hF81F};
    vecs[1]  = '{0, 3, 7, 16'hF81F};
    vecs[2]  = '{1, 0, 0, 16'hFFFF};
    vecs[3]  = '{1, 0, 1, 16'hFFE0};
    vecs[4]  = '{1, 1, 2, 16'h07FF};
    vecs[5]  = '{1, 1, 3, 16'h07E0};
    vecs[6]  = '{1, 2, 4, 16'hF81F};
    vecs[7]  = '{1, 2, 5, 16'hF800};
    vecs[8]  = '{1, 3, 6, 16'h001F};
    vecs[9]  = '{1, 3, 7, 16'h0000};
    vecs[10] = '{2, 0, 0, 16'h0000};
    vecs[11] = '{2, 2, 3, 16'h0005};
    vecs[12] = '{2, 3, 7, 16'h000A};
    vecs[13] = '{3, 0, 0, 16'h0000};
    vecs[14] = '{3, 1, 0, 16'h0008};
    vecs[15] = '{3, 3, 7, 16'h001F};
    vecs[16] = '{4, 0, 0, 16'h0000};
    vecs[17] = '{4, 2, 5, 16'h0015};
    vecs[18] = '{5, 0, 3, 16'h07E0};
    vecs[19] = '{6, 0, 0, 16'h07E0};
    vecs[20] = '{6, 3, 7, 16'h07E0};

    #12;
    check("rst_vsync", vsync, 1'b0);
    check("rst_href", href, 1'b0);
    check("rst_d", d, 8'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_sum", frame_sum, 16'd0);
    check("rst_d_b", d_b, 8'd0);

    @(negedge pclk);
    rst = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) run_frame(k, 1, k == 5);

    busy = 0;
    hits = 0;
    repeat (60) begin
      @(negedge pclk);
      busy += int'(vsync | href);
      hits += int'(frame_done);
    end
    check("idle_vsync_href", busy, 0);
    check("idle_frame_done", hits, 0);

    enable = 1'b1;
    @(negedge pclk);
    check("reassert_vsync", vsync, 1'b1);

    busy = 0;
    while (href !== 1'b1 && busy < 200) begin
      @(negedge pclk);
      busy++;
    end
    check("href_after_reassert", href, 1'b1);
    repeat (3) @(negedge pclk);
    check("pre_rst_d", d, 8'hE0);
    check("pre_rst_d_b", d_b, 8'h07);
    #2 rst = 1'b1;
    #1;
    check("async_rst_href", href, 1'b0);
    check("async_rst_d", d, 8'd0);
    check("async_rst_vsync", vsync, 1'b0);
    check("async_rst_d_b", d_b, 8'd0);
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    run_frame(6, 1, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("pix_a_f%0d_y%0d_x%0d", vecs[i].frame, vecs[i].y, vecs[i].x),
            cap_a[vecs[i].frame][vecs[i].y][vecs[i].x], vecs[i].exp_pix);
      check($sformatf("pix_b_f%0d_y%0d_x%0d", vecs[i].frame, vecs[i].y, vecs[i].x),
            cap_b[vecs[i].frame][vecs[i].y][vecs[i].x], vecs[i].exp_pix);
    end

    for (int k = 3; k <= 4; k++) begin
      int bad;
      bad = 0;
      for (int p = 0; p < 32; p++)
        if (cap_a[k][p / 8][p % 8] !== 16'(p)) bad++;
      check($sformatf("count_seq_f%0d", k), bad, 0);
      check($sformatf("frame_sum_f%0d", k), fsum_cap[k], SUM_COUNT);
    end
    check("frame_sum_f6", fsum_cap[6], SUM_GREEN);
    check("first_byte_hi", first_a[0], 8'hF8);
    check("first_byte_lo", first_b[0], 8'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
